// File: rtl/timer_display_driver.sv
// Binary-to-BCD display driver for the countdown timer: iterative double-dabble
// conversion feeding a 3-digit multiplexed 7-segment scan with leading-zero blanking.
module timer_display_driver #(
    parameter int unsigned SCAN_DIV   = 4,
    parameter logic [7:0]  BLANK_CODE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t           state;
    logic [7:0]       shadow;
    logic [7:0]       bin;
    logic [11:0]      bcd;
    logic [11:0]      bcd_adj;
    logic [2:0]       it;

    logic [2:0][3:0]  digit;
    logic [2:0]       blank;
    logic [2:0][3:0]  digit_next;
    logic [2:0]       blank_next;

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;
    logic [1:0]       idx_next;
    logic             wrap;

    function automatic logic [6:0] pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Add-3 correction per nibble; the largest nibble reached is 9, so no carry crosses nibbles.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            bcd_adj[n*4 +: 4] = (bcd[n*4 +: 4] >= 4'd5) ? bcd[n*4 +: 4] + 4'd3 : bcd[n*4 +: 4];
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        digit_next = digit;
        blank_next = blank;
        if (state == COMMIT) begin
            if (shadow == BLANK_CODE) begin
                blank_next = 3'b111;
            end else begin
                digit_next = {bcd[11:8], bcd[7:4], bcd[3:0]};
                blank_next = {bcd[11:8] == 4'd0, (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0), 1'b0};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= BLANK_CODE;
            bin    <= '0;
            bcd    <= '0;
            it     <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != shadow) begin
                        shadow <= value;
                        busy   <= 1'b1;
                        if (value == BLANK_CODE) begin
                            state <= COMMIT;
                        end else begin
                            bin   <= value;
                            bcd   <= '0;
                            it    <= '0;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
                    it         <= it + 3'd1;
                    if (it == 3'd7) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Digit registers power up blank so nothing lights before the first real value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= '0;
            blank <= 3'b111;
        end else begin
            digit <= digit_next;
            blank <= blank_next;
        end
    end

    assign wrap     = (scan_cnt == CNT_MAX);
    assign idx_next = (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;

    // Scan reads the post-commit digit values, so a commit on a wrap edge is shown immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            an        <= 3'b001;
            seg       <= 7'h00;
        end else if (wrap) begin
            scan_cnt  <= '0;
            digit_idx <= idx_next;
            an        <= 3'b001 << idx_next;
            seg       <= blank_next[idx_next] ? 7'h00 : pattern(digit_next[idx_next]);
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_timer_display_driver.sv
// Bench for timer_display_driver: directed scenarios plus random values, compared each
// cycle against an arithmetic model of the conversion latency and digit scan.
module tb_timer_display_driver;

    localparam logic [7:0] BLANK = 8'hFF;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic [6:0] seg4, seg1;
    logic [2:0] an4, an1;
    logic       busy4, busy1;

    timer_display_driver #(.SCAN_DIV(4), .BLANK_CODE(BLANK)) dut4 (
        .clk(clk), .reset(reset), .value(value), .seg(seg4), .an(an4), .busy(busy4)
    );

    timer_display_driver #(.SCAN_DIV(1), .BLANK_CODE(BLANK)) dut1 (
        .clk(clk), .reset(reset), .value(value), .seg(seg1), .an(an1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference state: converter as a latency countdown, display as a plain integer.
    logic [7:0] m_shadow, m_pending, m_disp;
    int         m_left;
    int         m_cnt4, m_idx4, m_idx1;
    logic [2:0] m_an4, m_an1;
    logic [6:0] m_seg4, m_seg1;
    logic       m_busy;

    function automatic logic [6:0] seg_of(input logic [7:0] v, input int idx);
        int n;
        if (v == BLANK) return 7'h00;
        n = int'(v);
        if (idx == 0) return pat[n % 10];
        if (idx == 1) return (n < 10) ? 7'h00 : pat[(n / 10) % 10];
        return (n < 100) ? 7'h00 : pat[n / 100];
    endfunction

    task automatic model_reset();
        m_shadow = BLANK;
        m_pending = BLANK;
        m_disp   = BLANK;
        m_left   = 0;
        m_cnt4   = 0;
        m_idx4   = 0;
        m_idx1   = 0;
        m_an4    = 3'b001;
        m_an1    = 3'b001;
        m_seg4   = 7'h00;
        m_seg1   = 7'h00;
        m_busy   = 1'b0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_left == 0) begin
            if (value !== m_shadow) begin
                m_shadow  = value;
                m_pending = value;
                m_left    = (value == BLANK) ? 1 : 9;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_disp = m_pending;
        end
        m_busy = (m_left != 0);
        if (m_cnt4 == 3) begin
            m_cnt4 = 0;
            m_idx4 = (m_idx4 + 1) % 3;
            m_an4  = 3'(1 << m_idx4);
            m_seg4 = seg_of(m_disp, m_idx4);
        end else begin
            m_cnt4++;
        end
        m_idx1 = (m_idx1 + 1) % 3;
        m_an1  = 3'(1 << m_idx1);
        m_seg1 = seg_of(m_disp, m_idx1);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("an4",   8'(an4),   8'(m_an4));
        check("seg4",  8'(seg4),  8'(m_seg4));
        check("busy4", 8'(busy4), 8'(m_busy));
        check("an1",   8'(an1),   8'(m_an1));
        check("seg1",  8'(seg1),  8'(m_seg1));
        check("busy1", 8'(busy1), 8'(m_busy));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        // Reset with blank code, then watch the blank display scan.
        reset = 1'b1;
        value = BLANK;
        model_reset();
        #1;
        check("rst_an",   8'(an4),   8'h01);
        check("rst_seg",  8'(seg4),  8'h00);
        check("rst_busy", 8'(busy4), 8'h00);
        run(2);
        reset = 1'b0;
        run(12);

        // 123 converts in 9 busy cycles, then scans 4F, 5B, 06.
        value = 8'd123;
        run(30);

        // Leading-zero suppression and explicit zero.
        value = 8'd7;
        run(20);
        value = 8'd0;
        run(20);

        // Max value, then changes during conversion: the last value wins, 9 is skipped.
        value = 8'd254;
        run(3);
        value = 8'd9;
        run(3);
        value = 8'd10;
        run(30);

        // Holding the shown value produces no activity.
        run(10);

        // Async reset in the middle of a conversion.
        value = 8'd77;
        run(5);
        value = BLANK;
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("midrst_busy", 8'(busy4), 8'h00);
        check("midrst_seg",  8'(seg4),  8'h00);
        check("midrst_an",   8'(an4),   8'h01);
        #1 reset = 1'b0;
        run(15);
        value = 8'd42;
        run(25);
        value = 8'd42;
        run(8);

        // Blank code after a value: one busy cycle, then all dark.
        value = 8'd5;
        run(15);
        value = BLANK;
        run(15);

        // Random values with random hold times, including blank code.
        repeat (40) begin
            if ($urandom_range(0, 7) == 0) value = BLANK;
            else value = 8'($urandom_range(0, 254));
            run(int'($urandom_range(1, 30)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
